fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end of the five-stage pipeline. Owns the architectural fetch PC and issues word reads on the SRAM-like instruction port, keeping at most one read outstanding. Delivers `{pc, pcplus4, instr}` into the decode pipeline register through a one-entry valid/ready output slot. Redirects from branch resolution and exceptions take effect immediately, and any in-flight stale read is squashed.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: fetch PC loaded on reset.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_req`  out  1  read request valid.
- `inst_addr`  out  32  read address; always equals the current fetch PC.
- `inst_addr_ok`  in  1  request accepted in this cycle.
- `inst_data_ok`  in  1  read data valid in this cycle; cannot be back-pressured.
- `inst_rdata`  in  32  returned instruction word.
- `br_valid`  in  1  branch/jump redirect request.
- `br_target`  in  32  branch/jump target.
- `exc_valid`  in  1  exception/ERET redirect request; has priority over `br_valid`.
- `exc_target`  in  32  exception/ERET target.
- `d_valid`  out  1  output slot holds a fetched instruction.
- `d_ready`  in  1  decode register accepts the slot this cycle.
- `d_pc`  out  32  PC of the slot instruction.
- `d_pcplus4`  out  32  `d_pc + 4`, modulo 2^32.
- `d_instr`  out  32  instruction word; 0 (NOP) when `d_adel` is set.
- `d_adel`  out  1  fetch address error: `d_pc[1:0] != 0`.

## Operation
- State registers: `state` ∈ {REQ, WAIT, FAULT}, fetch PC `pc_q`, in-flight PC `req_pc`, `discard` flag, and the output slot (`d_*`).
- Slot free: `!d_valid || d_ready`. A slot is consumed when `d_valid && d_ready`.
- REQ:
  - If `pc_q[1:0] != 0`: issue no request. When the slot is free, load the slot with `{pc_q, pc_q+4, 0, adel=1}` and go to FAULT.
  - Otherwise, `inst_req = slot free`. On `inst_req && inst_addr_ok`: `req_pc <= pc_q`, `pc_q <= pc_q + 4`, go to WAIT.
- WAIT (`inst_req = 0`):
  - On `inst_data_ok` with `discard = 0`: load the slot with `{req_pc, req_pc+4, inst_rdata, 0}`, go to REQ.
  - On `inst_data_ok` with `discard = 1`: drop the data, clear `discard`, go to REQ.
- Slot-free invariant: a request is issued only when the slot is free, and only this block fills the slot. The slot is therefore always free when data returns, so no skid buffer is needed.
- FAULT: `inst_req = 0`. Stays in FAULT until a redirect arrives.
- Redirect: `redir = exc_valid | br_valid`; target is `exc_target` if `exc_valid`, else `br_target`. When `redir` is high:
  - `pc_q <= target`.
  - `d_valid <= 0`; the slot is flushed even if `d_ready` is high.
  - State becomes REQ, unless a read remains outstanding.
  - Outstanding read: if in WAIT without `inst_data_ok`, or in REQ with `inst_addr_ok` this same cycle, set `discard <= 1` and go to/stay in WAIT.
  - In WAIT with `inst_data_ok` this same cycle: the returning data is dropped, and the next state is REQ.
- `inst_req` is forced to 0 while `resetn` is low.
- `d_pcplus4` and `pc_q + 4` wrap modulo 2^32.

## Timing
- Reset values:
  - `state` = REQ, `pc_q` = `RESET_PC`, `discard` = 0.
  - `d_valid` = 0, `d_pc` = 0, `d_pcplus4` = 0, `d_instr` = 0, `d_adel` = 0.
  - `inst_req` = 0 while `resetn` is low.
- First request is issued in the first cycle after `resetn` rises, at address `RESET_PC`.
- Latency: `addr_ok` at cycle t, `data_ok` at t+k (k ≥ 1), `d_valid` high from t+k+1.
- Peak throughput is one instruction per 2 cycles, reached with k = 1 and `d_ready` held high.
- `d_*` remains stable while `d_valid && !d_ready`.
- A redirect at cycle t: `inst_addr` = target at t+1 if no read is outstanding; otherwise one cycle after the squashed `data_ok`.
- `resetn` asserted mid-read: state clears immediately. Any `data_ok` arriving after reset is released is ignored while in REQ; the memory side must be reset together with this block.

## Test plan
- Reset release, `addr_ok` = 1, `data_ok` one cycle later with `inst_rdata` = 0x2408_0001:
  - `inst_addr` = 0xBFC0_0000.
  - `d_valid` two cycles after the request.
  - `d_pc` = 0xBFC0_0000, `d_pcplus4` = 0xBFC0_0004, `d_instr` = 0x2408_0001.
  - Next `inst_addr` = 0xBFC0_0004.
- `d_ready` held low for 5 cycles with the slot full:
  - `inst_req` stays 0 and `d_*` is stable.
  - After `d_ready` rises, a request is issued in the same cycle.
- `br_valid` with `br_target` = 0x8000_0100 while in WAIT:
  - `d_valid` drops next cycle.
  - The returning data is dropped.
  - The next request address is 0x8000_0100, and the next `d_pc` is 0x8000_0100.
- `br_valid` and `exc_valid` both asserted (0x8000_0100 / 0xBFC0_0380) on the same cycle as `addr_ok`:
  - The read is squashed.
  - The next request address is 0xBFC0_0380.
- Redirect to 0x8000_0102:
  - No request is issued.
  - Slot contents: `d_adel` = 1, `d_instr` = 0, `d_pc` = 0x8000_0102.
  - Fetch stays idle until a redirect to 0xBFC0_0380, which resumes requests.
- `pc_q` = 0xFFFF_FFFC fetch: `d_pcplus4` = 0x0000_0000 and next `inst_addr` = 0x0000_0000.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: the SRAM-like instruction read port and the
// valid/ready output slot feeding the decode pipeline register.
interface fetch_stage_if;
  // instruction read port
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  // decode output slot
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_pc;
  logic [31:0] d_pcplus4;
  logic [31:0] d_instr;
  logic        d_adel;

  // Fetch stage view: drives requests and the output slot.
  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output d_valid, d_pc, d_pcplus4, d_instr, d_adel,
    input  d_ready
  );

  // Environment view: memory responder and decode stage.
  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  d_valid, d_pc, d_pcplus4, d_instr, d_adel,
    output d_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one word
// read outstanding, and hands {pc, pc+4, instr, adel} to decode through a
// one-entry valid/ready slot. Redirects take effect immediately; a read that
// is still in flight when a redirect arrives is squashed via the discard flag.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic          clk,
  input  logic          resetn,
  fetch_stage_if.master bus,
  input  logic          br_valid,
  input  logic [31:0]   br_target,
  input  logic          exc_valid,
  input  logic [31:0]   exc_target
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]  state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] req_pc_q,    req_pc_d;
  logic        discard_q,   discard_d;
  logic        d_valid_q,   d_valid_d;
  logic [31:0] d_pc_q,      d_pc_d;
  logic [31:0] d_pcplus4_q, d_pcplus4_d;
  logic [31:0] d_instr_q,   d_instr_d;
  logic        d_adel_q,    d_adel_d;

  logic        slot_free_s;
  logic        slot_take_s;
  logic        pc_misaligned_s;
  logic        inst_req_s;
  logic        accept_s;
  logic        redir_s;
  logic [31:0] redir_target_s;
  logic        outstanding_s;

  assign slot_free_s     = ~d_valid_q | bus.d_ready;
  assign slot_take_s     = d_valid_q & bus.d_ready;
  assign pc_misaligned_s = (pc_q[1:0] != 2'b00);
  // Only request when the slot is free: returning data then always has a
  // place to land, so no skid buffer is needed.
  assign inst_req_s      = resetn & (state_q == ST_REQ) & ~pc_misaligned_s & slot_free_s;
  assign accept_s        = inst_req_s & bus.inst_addr_ok;
  assign redir_s         = exc_valid | br_valid;
  assign redir_target_s  = exc_valid ? exc_target : br_target;
  // A read stays in flight past this cycle if we are waiting without data,
  // or a new request is being accepted right now.
  assign outstanding_s   = ((state_q == ST_WAIT) & ~bus.inst_data_ok) |
                           ((state_q == ST_REQ) & accept_s);

  assign bus.inst_req  = inst_req_s;
  assign bus.inst_addr = pc_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_pc      = d_pc_q;
  assign bus.d_pcplus4 = d_pcplus4_q;
  assign bus.d_instr   = d_instr_q;
  assign bus.d_adel    = d_adel_q;

  // Next-state logic: redirect has priority over normal fetch progress.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    discard_d   = discard_q;
    d_valid_d   = d_valid_q;
    d_pc_d      = d_pc_q;
    d_pcplus4_d = d_pcplus4_q;
    d_instr_d   = d_instr_q;
    d_adel_d    = d_adel_q;

    if (redir_s) begin
      pc_d      = redir_target_s;
      d_valid_d = 1'b0;
      if (outstanding_s) begin
        discard_d = 1'b1;
        state_d   = ST_WAIT;
      end else begin
        // Includes WAIT with data_ok now: that data is simply dropped.
        discard_d = 1'b0;
        state_d   = ST_REQ;
      end
    end else begin
      if (slot_take_s) begin
        d_valid_d = 1'b0;
      end else begin
        d_valid_d = d_valid_q;
      end

      case (state_q)
        ST_REQ: begin
          if (pc_misaligned_s) begin
            if (slot_free_s) begin
              d_valid_d   = 1'b1;
              d_pc_d      = pc_q;
              d_pcplus4_d = pc_q + 32'd4;
              d_instr_d   = 32'd0;
              d_adel_d    = 1'b1;
              state_d     = ST_FAULT;
            end else begin
              state_d = ST_REQ;
            end
          end else if (accept_s) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (bus.inst_data_ok) begin
            if (!discard_q) begin
              d_valid_d   = 1'b1;
              d_pc_d      = req_pc_q;
              d_pcplus4_d = req_pc_q + 32'd4;
              d_instr_d   = bus.inst_rdata;
              d_adel_d    = 1'b0;
            end else begin
              d_valid_d = d_valid_d;
            end
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  // State and output-slot registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'd0;
      discard_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      d_pc_q      <= 32'd0;
      d_pcplus4_q <= 32'd0;
      d_instr_q   <= 32'd0;
      d_adel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      discard_q   <= discard_d;
      d_valid_q   <= d_valid_d;
      d_pc_q      <= d_pc_d;
      d_pcplus4_q <= d_pcplus4_d;
      d_instr_q   <= d_instr_d;
      d_adel_q    <= d_adel_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs are driven 1 time unit after the
// rising edge and outputs are checked 1 unit later, well away from the edge.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic [31:0] exc_target;
  int          checks = 0;
  int          failures = 0;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .br_valid  (br_valid),
    .br_target (br_target),
    .exc_valid (exc_valid),
    .exc_target(exc_target)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic aok, input logic dok, input logic [31:0] rdata,
                     input logic rdy, input logic bv, input logic [31:0] bt,
                     input logic ev, input logic [31:0] et);
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok;
    bus.inst_rdata   = rdata;
    bus.d_ready      = rdy;
    br_valid         = bv;
    br_target        = bt;
    exc_valid        = ev;
    exc_target       = et;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (3) tick();
    drv(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", bus.inst_req); end
    checks++; if (bus.d_valid !== 1'b0) begin failures++; $display("FAIL rst_dvalid got=%0b exp=0", bus.d_valid); end
    checks++; if (bus.d_pc !== 32'd0 || bus.d_pcplus4 !== 32'd0) begin failures++; $display("FAIL rst_dpc got=%h/%h exp=0/0", bus.d_pc, bus.d_pcplus4); end
    checks++; if (bus.d_instr !== 32'd0 || bus.d_adel !== 1'b0) begin failures++; $display("FAIL rst_dinstr got=%h/%0b exp=0/0", bus.d_instr, bus.d_adel); end
    checks++; if (bus.inst_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL rst_addr got=%h exp=bfc00000", bus.inst_addr); end
    resetn = 1'b1;
    #1;
    checks++; if (bus.inst_req !== 1'b1) begin failures++; $display("FAIL first_req got=%0b exp=1", bus.inst_req); end
  endtask

  task automatic test_first_fetch();
    // addr_ok accepted in this cycle
    tick();
    drv(1'b0, 1'b1, 32'h2408_0001, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL wait_req got=%0b exp=0", bus.inst_req); end
    tick();
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.d_valid !== 1'b1) begin failures++; $display("FAIL ff_dvalid got=%0b exp=1", bus.d_valid); end
    checks++; if (bus.d_pc !== 32'hBFC0_0000) begin failures++; $display("FAIL ff_dpc got=%h exp=bfc00000", bus.d_pc); end
    checks++; if (bus.d_pcplus4 !== 32'hBFC0_0004) begin failures++; $display("FAIL ff_dpc4 got=%h exp=bfc00004", bus.d_pcplus4); end
    checks++; if (bus.d_instr !== 32'h2408_0001 || bus.d_adel !== 1'b0) begin failures++; $display("FAIL ff_dinstr got=%h/%0b exp=24080001/0", bus.d_instr, bus.d_adel); end
    checks++; if (bus.inst_addr !== 32'hBFC0_0004) begin failures++; $display("FAIL ff_nextaddr got=%h exp=bfc00004", bus.inst_addr); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL bp_req[%0d] got=%0b exp=0", i, bus.inst_req); end
      checks++; if (bus.d_valid !== 1'b1 || bus.d_pc !== 32'hBFC0_0000 || bus.d_instr !== 32'h2408_0001) begin
        failures++; $display("FAIL bp_slot[%0d] got=%0b/%h/%h exp=1/bfc00000/24080001", i, bus.d_valid, bus.d_pc, bus.d_instr);
      end
      tick();
      drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    end
    drv(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0004) begin
      failures++; $display("FAIL bp_release got=%0b/%h exp=1/bfc00004", bus.inst_req, bus.inst_addr);
    end
    tick();
  endtask

  task automatic test_branch_wait();
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'd0);
    tick();
    drv(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.d_valid !== 1'b0) begin failures++; $display("FAIL br_dvalid got=%0b exp=0", bus.d_valid); end
    checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL br_noreq got=%0b exp=0", bus.inst_req); end
    tick();
    drv(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.d_valid !== 1'b0) begin failures++; $display("FAIL br_dropped got=%0b exp=0", bus.d_valid); end
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_0100) begin
      failures++; $display("FAIL br_addr got=%0b/%h exp=1/80000100", bus.inst_req, bus.inst_addr);
    end
    tick();
    drv(1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.d_valid !== 1'b1 || bus.d_pc !== 32'h8000_0100 || bus.d_instr !== 32'h1111_1111) begin
      failures++; $display("FAIL br_slot got=%0b/%h/%h exp=1/80000100/11111111", bus.d_valid, bus.d_pc, bus.d_instr);
    end
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_0104) begin
      failures++; $display("FAIL br_b2b got=%0b/%h exp=1/80000104", bus.inst_req, bus.inst_addr);
    end
  endtask

  task automatic test_exc_priority();
    drv(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0100, 1'b1, 32'hBFC0_0380);
    tick();
    drv(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.d_valid !== 1'b0 || bus.inst_req !== 1'b0) begin
      failures++; $display("FAIL exc_squash got=%0b/%0b exp=0/0", bus.d_valid, bus.inst_req);
    end
    checks++; if (bus.inst_addr !== 32'hBFC0_0380) begin failures++; $display("FAIL exc_prio got=%h exp=bfc00380", bus.inst_addr); end
    tick();
    drv(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.d_valid !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0380) begin
      failures++; $display("FAIL exc_req got=%0b/%0b/%h exp=0/1/bfc00380", bus.d_valid, bus.inst_req, bus.inst_addr);
    end
    tick();
    drv(1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.d_valid !== 1'b1 || bus.d_pc !== 32'hBFC0_0380 || bus.d_pcplus4 !== 32'hBFC0_0384 || bus.d_instr !== 32'h2222_2222) begin
      failures++; $display("FAIL exc_slot got=%0b/%h/%h/%h exp=1/bfc00380/bfc00384/22222222", bus.d_valid, bus.d_pc, bus.d_pcplus4, bus.d_instr);
    end
  endtask

  task automatic test_adel();
    // slot full, d_ready low: the redirect must still flush it
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h8000_0102, 1'b0, 32'd0);
    tick();
    drv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.d_valid !== 1'b0) begin failures++; $display("FAIL adel_flush got=%0b exp=0", bus.d_valid); end
    checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL adel_noreq got=%0b exp=0", bus.inst_req); end
    tick();
    drv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.d_valid !== 1'b1 || bus.d_adel !== 1'b1 || bus.d_instr !== 32'd0) begin
      failures++; $display("FAIL adel_slot got=%0b/%0b/%h exp=1/1/0", bus.d_valid, bus.d_adel, bus.d_instr);
    end
    checks++; if (bus.d_pc !== 32'h8000_0102 || bus.d_pcplus4 !== 32'h8000_0106) begin
      failures++; $display("FAIL adel_pc got=%h/%h exp=80000102/80000106", bus.d_pc, bus.d_pcplus4);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      drv(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL fault_idle[%0d] got=%0b exp=0", i, bus.inst_req); end
    end
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hBFC0_0380, 1'b0, 32'd0);
    tick();
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0380 || bus.d_valid !== 1'b0) begin
      failures++; $display("FAIL fault_resume got=%0b/%h/%0b exp=1/bfc00380/0", bus.inst_req, bus.inst_addr, bus.d_valid);
    end
  endtask

  task automatic test_wrap();
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
    tick();
    drv(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_req got=%0b/%h exp=1/fffffffc", bus.inst_req, bus.inst_addr);
    end
    tick();
    drv(1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.d_pc !== 32'hFFFF_FFFC || bus.d_pcplus4 !== 32'h0000_0000 || bus.d_instr !== 32'h3333_3333) begin
      failures++; $display("FAIL wrap_slot got=%h/%h/%h exp=fffffffc/0/33333333", bus.d_pc, bus.d_pcplus4, bus.d_instr);
    end
    checks++; if (bus.inst_addr !== 32'h0000_0000 || bus.inst_req !== 1'b1) begin
      failures++; $display("FAIL wrap_addr got=%h/%0b exp=0/1", bus.inst_addr, bus.inst_req);
    end
  endtask

  task automatic test_reset_midread();
    drv(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    resetn = 1'b0;
    #1;
    checks++; if (bus.inst_req !== 1'b0 || bus.d_valid !== 1'b0 || bus.inst_addr !== 32'hBFC0_0000) begin
      failures++; $display("FAIL midrst got=%0b/%0b/%h exp=0/0/bfc00000", bus.inst_req, bus.d_valid, bus.inst_addr);
    end
    tick();
    resetn = 1'b1;
    drv(1'b0, 1'b1, 32'h4444_4444, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++; if (bus.d_valid !== 1'b0 || bus.inst_addr !== 32'hBFC0_0000 || bus.inst_req !== 1'b1) begin
      failures++; $display("FAIL midrst_stray got=%0b/%h/%0b exp=0/bfc00000/1", bus.d_valid, bus.inst_addr, bus.inst_req);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_branch_wait();
    test_exc_priority();
    test_adel();
    test_wrap();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
